uart_tx_queue: RTL

//   Upstream feeder for the UART transmit side. Buffers bytes written by the host in a

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_sync_fifo.sv | 42 ++++
 rtl/uart_tx_queue.sv | 78 +++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and watchdog length helper for the UART transmit queue
package uart_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} txq_state_e;
  function automatic int calc_timeout(input int clk_freq, input int baud_rate, input int to_bits);
    return to_bits * (clk_freq / baud_rate);
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO with registered full/empty/level; push while full and pop while empty are ignored
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  logic [AW:0] level_nxt;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign level_nxt = level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      full <= level_nxt == (AW+1)'(DEPTH);
      empty <= level_nxt == '0;
    end
  end
endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: FIFO-buffered byte feeder for a UART transmitter with per-frame watchdog
// Optional dropped-write counter port ovf_cnt enabled by UART_TXQ_OVF_CNT_EN.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600,
  parameter int DEPTH     = 16,
  parameter int TO_BITS   = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             din,
  output logic                   newd,
  input  logic                   donetx,
  output logic                   busy,
  output logic                   tx_timeout
`ifdef UART_TXQ_OVF_CNT_EN
  ,
  output logic [15:0]            ovf_cnt
`endif
);
  localparam int TIMEOUT_CYC = calc_timeout(clk_freq, baud_rate, TO_BITS);
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  txq_state_e state, state_nxt;
  logic [WD_W-1:0] wd;
  logic [7:0] head;
  logic pop, done, expire;
  uart_sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(wr_en),
    .pop(pop),
    .wr_data(wr_data),
    .rd_data(head),
    .full(full),
    .empty(empty),
    .level(level)
  );
  assign pop = state == IDLE && !empty;
  assign done = state == WAIT && donetx;
  // acknowledge beats expiry when both land on the same cycle
  assign expire = state == WAIT && !donetx && wd == WD_W'(TIMEOUT_CYC - 1);
  always_comb begin
    state_nxt = state;
    if (pop) state_nxt = ISSUE;
    else if (state == ISSUE) state_nxt = WAIT;
    else if (done || expire) state_nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      din <= '0;
      newd <= 1'b0;
      busy <= 1'b0;
      tx_timeout <= 1'b0;
      wd <= '0;
    end else begin
      state <= state_nxt;
      newd <= state == ISSUE;
      busy <= state_nxt != IDLE;
      tx_timeout <= expire;
      if (pop) din <= head;
      wd <= state == ISSUE ? '0 : (state == WAIT && wd != '1) ? wd + 1'b1 : wd;
    end
  end
`ifdef UART_TXQ_OVF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) ovf_cnt <= '0;
    else if (wr_en && full && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 1'b1;
  end
`endif
endmodule
